// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA beat engine.
package dma_pkg;
  localparam int BEATS       = 12;
  localparam int BEAT_W      = 32;
  localparam int DATA_W      = 381;
  localparam int PAD_W       = 3;
  localparam int ADDR_STRIDE = 4;
  localparam int TIMEOUT     = 1023;
  localparam int BUF_W       = BEATS * BEAT_W;
  localparam int BEAT_CW     = $clog2(BEATS);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} dma_state_e;
endpackage

// File: rtl/dma_watchdog.sv
// Per-beat stall watchdog: restarts on load, counts while waiting, flags expiry on the LIMIT-th cycle.
module dma_watchdog #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || load_i)             cnt_q <= '0;
    else if (count_i && !expire_o) cnt_q <= cnt_q + 1'b1;
  end

  assign expire_o = count_i && (cnt_q == CW'(LIMIT - 1));
endmodule

// File: rtl/dma_beat_engine.sv
// DMA responder: moves one 381-bit operand as twelve 32-bit single-outstanding beats.
// Optional per-beat watchdog enabled by defining DMA_TIMEOUT_EN.
module dma_beat_engine
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_rx_start,
  input  logic              dma_tx_start,
  input  logic [31:0]       dma_rx_address,
  input  logic [31:0]       dma_tx_address,
  input  logic [DATA_W-1:0] dma_tx_data,
  output logic [DATA_W-1:0] dma_rx_data,
  output logic              dma_done,
  output logic              dma_idle,
  output logic              dma_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);
  dma_state_e         state_q;
  logic [BEAT_CW-1:0] beat_q;
  logic [BUF_W-1:0]   buf_q;
  logic [DATA_W-1:0]  rx_data_q;
  logic [31:0]        addr_q;
  logic               idle_q, done_q, err_q, req_q, we_q;

  logic               start, start_tx, misaligned, wd_expire;
  logic [31:0]        start_addr;
  logic [BUF_W-1:0]   start_buf, buf_shift;

  // rx has priority when both starts arrive together
  assign start      = dma_rx_start | dma_tx_start;
  assign start_tx   = dma_tx_start & ~dma_rx_start;
  assign start_addr = dma_rx_start ? dma_rx_address : dma_tx_address;
  assign misaligned = |start_addr[1:0];
  assign start_buf  = {dma_tx_data, {PAD_W{1'b0}}};
  assign buf_shift  = {buf_q[BUF_W-BEAT_W-1:0], mem_rdata};

`ifdef DMA_TIMEOUT_EN
  logic waiting;
  assign waiting = (state_q == S_REQ && !mem_gnt) || (state_q == S_RESP && !mem_rvalid);

  dma_watchdog #(.LIMIT(TIMEOUT)) u_wd (
    .clk      (clk),
    .rst      (rst),
    .load_i   (!waiting),
    .count_i  (waiting),
    .expire_o (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      buf_q     <= '0;
      rx_data_q <= '0;
      addr_q    <= '0;
      idle_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          err_q  <= dma_rx_start & dma_tx_start;
          we_q   <= start_tx;
          buf_q  <= start_buf;
          beat_q <= '0;
          addr_q <= start_addr;
          idle_q <= 1'b0;
          if (misaligned) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (wd_expire) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (mem_gnt) begin
            req_q   <= 1'b0;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (wd_expire || (mem_rvalid && mem_err)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (mem_rvalid) begin
            buf_q <= buf_shift;
            if (beat_q == BEAT_CW'(BEATS - 1)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
              if (!we_q) rx_data_q <= buf_shift[BUF_W-1 -: DATA_W];
            end else begin
              beat_q  <= beat_q + 1'b1;
              addr_q  <= addr_q + 32'(ADDR_STRIDE);
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
          end
        end
        S_DONE: begin
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dma_rx_data = rx_data_q;
  assign dma_done    = done_q;
  assign dma_idle    = idle_q;
  assign dma_error   = err_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  // the buffer's top word is the beat in flight; rx shifts read data through it
  assign mem_wdata   = we_q ? buf_q[BUF_W-1 -: BEAT_W] : '0;
endmodule

// File: tb/tb_dma_beat_engine.sv
// Directed bench for dma_beat_engine with a transaction-level memory model and scoreboard.
module tb_dma_beat_engine;
  import dma_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dma_rx_start = 1'b0, dma_tx_start = 1'b0;
  logic [31:0]       dma_rx_address = '0, dma_tx_address = '0;
  logic [DATA_W-1:0] dma_tx_data = '0;
  logic [DATA_W-1:0] dma_rx_data;
  logic              dma_done, dma_idle, dma_error;
  logic              mem_req, mem_we;
  logic [31:0]       mem_addr, mem_wdata;
  logic              mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
  logic [31:0]       mem_rdata = '0;

  always #5 clk = ~clk;

  dma_beat_engine dut (
    .clk(clk), .rst(rst),
    .dma_rx_start(dma_rx_start), .dma_tx_start(dma_tx_start),
    .dma_rx_address(dma_rx_address), .dma_tx_address(dma_tx_address),
    .dma_tx_data(dma_tx_data), .dma_rx_data(dma_rx_data),
    .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // model state: what the current transfer must look like on the bus and at completion
  logic [31:0]       m_base = '0;
  logic              m_we = 1'b0;
  logic [383:0]      m_txbuf = '0;
  int                m_err_beat = -1;
  int                m_nreq = 0;
  logic [DATA_W-1:0] m_rx = '0;
  logic              m_err_exp = 1'b0;
  int                done_cnt = 0;
  bit                stall = 1'b0;
  bit                pend = 1'b0;
  logic [31:0]       pend_addr = '0;
  int                pend_idx = 0;
  logic [31:0]       first_wd = '0, last_wd = '0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ((a - 32'h1000) >> 2) + 32'd1;
  endfunction

  // memory responder and per-cycle scoreboard, away from the active edge
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    mem_rdata  = '0;
    if (rst) pend = 1'b0;
    if (pend) begin
      mem_rvalid = 1'b1;
      mem_rdata  = word_at(pend_addr);
      mem_err    = (pend_idx == m_err_beat);
      pend       = 1'b0;
    end
    mem_gnt = mem_req && !stall && !rst;
    if (mem_gnt) begin
      chk("beat_addr", 384'(mem_addr), 384'(m_base + 32'(4 * m_nreq)));
      chk("beat_we", 384'(mem_we), 384'(m_we));
      if (m_we) chk("beat_wdata", 384'(mem_wdata), 384'(m_txbuf[383 - 32*m_nreq -: 32]));
      if (m_nreq == 0) first_wd = mem_wdata;
      last_wd   = mem_wdata;
      pend      = 1'b1;
      pend_addr = mem_addr;
      pend_idx  = m_nreq;
      m_nreq++;
    end
    if (dma_done) begin
      done_cnt++;
      chk("done_error", 384'(dma_error), 384'(m_err_exp));
      chk("done_rx_data", 384'(dma_rx_data), 384'(m_rx));
    end
  end

  task automatic xfer(input string nm, input logic rx, input logic tx,
                      input logic [31:0] ra, input logic [31:0] ta, input logic [DATA_W-1:0] td,
                      input int eb, input int hold, input int stall_n, input int exp_lat, input bit to);
    logic [31:0]  base;
    logic         ok;
    logic [383:0] b;
    int           lat, exp_n;
    base = rx ? ra : ta;
    ok   = (base[1:0] == 2'b00);
    m_base = base; m_we = !rx; m_txbuf = {td, 3'b000};
    m_err_beat = eb; m_nreq = 0; done_cnt = 0;
    m_err_exp = (rx && tx) || !ok || (eb >= 0) || to;
    exp_n = (!ok || to) ? 0 : (eb >= 0 ? eb + 1 : BEATS);
    if (rx && ok && eb < 0 && !to) begin
      b = '0;
      for (int i = 0; i < BEATS; i++) b[383 - 32*i -: 32] = word_at(base + 32'(4*i));
      m_rx = b[383:3];
    end
    stall = (stall_n > 0);
    @(posedge clk); #1;
    dma_rx_start = rx; dma_tx_start = tx;
    dma_rx_address = ra; dma_tx_address = ta; dma_tx_data = td;
    lat = -1;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (k == hold) begin dma_rx_start = 1'b0; dma_tx_start = 1'b0; end
      if (k == 1) begin
        dma_tx_data = '0;
        chk({nm, "_req_c1"}, 384'(mem_req), 384'(ok));
        chk({nm, "_idle_c1"}, 384'(dma_idle), 384'(0));
      end
      if (k == stall_n) stall = 1'b0;
      if (dma_done) begin lat = k; break; end
    end
    stall = 1'b0;
    chk({nm, "_latency"}, 384'(lat), 384'(exp_lat));
    @(posedge clk); #1;
    chk({nm, "_idle_after"}, 384'(dma_idle), 384'(1));
    chk({nm, "_done_1cyc"}, 384'(dma_done), 384'(0));
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_count"}, 384'(done_cnt), 384'(1));
    chk({nm, "_nreq"}, 384'(m_nreq), 384'(exp_n));
    chk({nm, "_err_hold"}, 384'(dma_error), 384'(m_err_exp));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_idle"}, 384'(dma_idle), 384'(1));
    chk({nm, "_done"}, 384'(dma_done), 384'(0));
    chk({nm, "_error"}, 384'(dma_error), 384'(0));
    chk({nm, "_rx_data"}, 384'(dma_rx_data), 384'(0));
    chk({nm, "_req"}, 384'(mem_req), 384'(0));
    chk({nm, "_we"}, 384'(mem_we), 384'(0));
    chk({nm, "_addr"}, 384'(mem_addr), 384'(0));
    chk({nm, "_wdata"}, 384'(mem_wdata), 384'(0));
  endtask

  initial begin
    logic [383:0] lit;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // zero-wait rx of words 1..12
    xfer("rx", 1'b1, 1'b0, 32'h1000, 32'h0, '0, -1, 1, 0, 25, 1'b0);
    lit = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA, 32'hB, 32'hC};
    chk("rx_literal", 384'(dma_rx_data), 384'(lit[383:3]));
    chk("rx_error", 384'(dma_error), 384'(0));

    // tx of all ones; input data dropped to zero after the start cycle
    xfer("tx", 1'b0, 1'b1, 32'h0, 32'h1000, '1, -1, 1, 0, 25, 1'b0);
    chk("tx_beat0", 384'(first_wd), 384'(32'hFFFFFFFF));
    chk("tx_beat11", 384'(last_wd), 384'(32'hFFFFFFF8));
    chk("tx_rx_untouched", 384'(dma_rx_data), 384'(lit[383:3]));

    // bus error on beat 5 aborts, keeps previous rx data
    xfer("rxerr", 1'b1, 1'b0, 32'h2000, 32'h0, '0, 5, 1, 0, 13, 1'b0);
    chk("rxerr_six_reqs", 384'(m_nreq), 384'(6));
    chk("rxerr_rx_kept", 384'(dma_rx_data), 384'(lit[383:3]));

    // misaligned base: no traffic, immediate done with error
    xfer("misalign", 1'b1, 1'b0, 32'h1002, 32'h0, '0, -1, 1, 0, 1, 1'b0);

    // both starts: rx wins, error flagged
    xfer("both", 1'b1, 1'b1, 32'h2000, 32'h3000, '1, -1, 1, 0, 25, 1'b0);

    // start held two cycles yields one transfer
    xfer("hold2", 1'b1, 1'b0, 32'h1040, 32'h0, '0, -1, 2, 0, 25, 1'b0);

    // grant withheld for the first 4 cycles of beat 0
    xfer("stall", 1'b0, 1'b1, 32'h0, 32'h1100, {12{32'hA5C3_0F96}}, -1, 1, 5, 29, 1'b0);

`ifdef DMA_TIMEOUT_EN
    xfer("timeout", 1'b1, 1'b0, 32'h1000, 32'h0, '0, -1, 1, 100000, 1024, 1'b1);
`endif

    // reset during beat 3 of an rx
    m_base = 32'h1000; m_we = 1'b0; m_err_beat = -1; m_nreq = 0; done_cnt = 0;
    @(posedge clk); #1;
    dma_rx_start = 1'b1; dma_rx_address = 32'h1000;
    @(posedge clk); #1;
    dma_rx_start = 1'b0;
    for (int k = 0; k < 40 && m_nreq < 4; k++) begin
      @(negedge clk); #1;
    end
    chk("rst_reached_beat3", 384'(m_nreq), 384'(4));
    rst = 1'b1;
    m_rx = '0;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", 384'(done_cnt), 384'(0));
    chk("midrst_no_more_reqs", 384'(m_nreq), 384'(4));

    xfer("recover", 1'b1, 1'b0, 32'h1000, 32'h0, '0, -1, 1, 0, 25, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
